// File: rtl/if_unit.sv
// Instruction fetch unit: prefetch queue feeding the decoder over a valid/ready handshake.
// Optional starvation counter (stall_cnt port) is built when IF_PERF_CNT_EN is defined.
module if_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    output logic              i_valid,
    output logic [15:0]       i_reg,
    input  logic              i_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt
`ifdef IF_PERF_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              halted_q, halted_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [15:0]       queue_q [DEPTH];
    logic [15:0]       queue_d [DEPTH];

    logic              do_issue;
    logic              do_push;
    logic              do_pop;

    // A slot is reserved at issue time, so only one request is ever in flight
    // and the push on its acknowledge always finds room.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        halted_d   = halted_q;
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;
        queue_d    = queue_q;

        do_issue = (state_q == S_IDLE) && !redirect && !halted_q && !halt &&
                   (count_q < CNT_W'(DEPTH));
        do_push  = (state_q == S_WAIT) && mem_ack && !redirect;
        do_pop   = (count_q != '0) && i_ready && !redirect;

        case (state_q)
            S_IDLE: begin
                if (do_issue) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = pc_q;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = S_IDLE;
                    pc_d      = pc_q + ADDR_W'(1);
                end else if (redirect) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        if (do_push) begin
            queue_d[tail_q] = mem_rdata;
            tail_d          = tail_q + PTR_W'(1);
        end
        if (do_pop) begin
            head_d = head_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end

        if (halt) begin
            halted_d = 1'b1;
        end

        // Redirect wins over everything: the in-flight word (if any) is dropped
        // by DRAIN or by skipping the push above.
        if (redirect) begin
            pc_d     = redirect_pc;
            halted_d = 1'b0;
            count_d  = '0;
            head_d   = '0;
            tail_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
            halted_q   <= 1'b0;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                queue_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            halted_q   <= halted_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            queue_q    <= queue_d;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign i_valid  = (count_q != '0);
    assign i_reg    = queue_q[head_q];

`ifdef IF_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Counts cycles the decoder is starved while fetch is still active.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!i_valid && !halted_q && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_unit.sv
// Directed self-checking bench for if_unit with a small word-addressed memory model.
module tb_if_unit;

    logic        clk;
    logic        rst_n;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        i_valid;
    logic [15:0] i_reg;
    logic        i_ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;
`ifdef IF_PERF_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    int          ack_delay;
    bit          ack_en;
    int          wait_cnt;
    logic [15:0] fetch_log [$];
    logic [15:0] deliv_log [$];

    if_unit #(
        .ADDR_W  (16),
        .DEPTH   (2),
        .RESET_PC(16'h0000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .i_valid    (i_valid),
        .i_reg      (i_reg),
        .i_ready    (i_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halt       (halt)
`ifdef IF_PERF_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents
    function automatic logic [15:0] rom(input logic [15:0] a);
        case (a)
            16'h0000: rom = 16'h0493;
            16'h0001: rom = 16'h8190;
            16'h0002: rom = 16'h2240;
            16'h0010: rom = 16'h0010;
            16'h0011: rom = 16'h0011;
            default:  rom = a ^ 16'h5A00;
        endcase
    endfunction

    assign mem_rdata = rom(mem_addr);
    assign mem_ack   = mem_req && ack_en && (wait_cnt >= ack_delay);

    always @(posedge clk) begin
        if (!mem_req || mem_ack) wait_cnt <= 0;
        else                     wait_cnt <= wait_cnt + 1;
    end

    // Handshake monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_req && mem_ack) fetch_log.push_back(mem_addr);
            if (i_valid && i_ready && !redirect) deliv_log.push_back(i_reg);
        end
    end

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        rst_n       = 1'b0;
        i_ready     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        halt        = 1'b0;
        ack_en      = 1'b1;
        ack_delay   = 0;
        tick(2);
        rst_n = 1'b1;
        fetch_log.delete();
        deliv_log.delete();
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        i_ready     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        halt        = 1'b0;
        ack_en      = 1'b0;
        ack_delay   = 0;
        tick(2);
        checks++; if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_req got=%b want=0", mem_req); end
        checks++; if (mem_addr !== 16'h0000) begin failures++; $display("[TB] FAIL reset_mem_addr got=%h want=0000", mem_addr); end
        checks++; if (i_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_i_valid got=%b want=0", i_valid); end
        checks++; if (i_reg !== 16'h0000) begin failures++; $display("[TB] FAIL reset_i_reg got=%h want=0000", i_reg); end
`ifdef IF_PERF_CNT_EN
        checks++; if (stall_cnt !== 16'h0000) begin failures++; $display("[TB] FAIL reset_stall_cnt got=%0d want=0", stall_cnt); end
`endif
        rst_n = 1'b1;
        tick(2);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin failures++; $display("[TB] FAIL first_issue req=%b addr=%h want req=1 addr=0000", mem_req, mem_addr); end
        rst_n = 1'b0;
        tick(1);
        checks++; if (mem_req !== 1'b0 || mem_addr !== 16'h0000) begin failures++; $display("[TB] FAIL midtxn_reset req=%b addr=%h want req=0 addr=0000", mem_req, mem_addr); end
    endtask

    task automatic test_stream();
        logic [15:0] exp_w [3];
        exp_w[0] = 16'h0493; exp_w[1] = 16'h8190; exp_w[2] = 16'h2240;
        apply_reset();
        i_ready = 1'b1;
        tick(8);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (fetch_log.size() <= i || fetch_log[i] !== 16'(i)) begin
                failures++;
                $display("[TB] FAIL stream_addr[%0d] got=%h want=%h", i, (fetch_log.size() > i) ? fetch_log[i] : 16'hxxxx, 16'(i));
            end
            checks++;
            if (deliv_log.size() <= i || deliv_log[i] !== exp_w[i]) begin
                failures++;
                $display("[TB] FAIL stream_word[%0d] got=%h want=%h", i, (deliv_log.size() > i) ? deliv_log[i] : 16'hxxxx, exp_w[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] held;
        apply_reset();
        tick(6);
        held = i_reg;
        tick(6);
        checks++; if (fetch_log.size() != 2) begin failures++; $display("[TB] FAIL bp_fetch_count got=%0d want=2", fetch_log.size()); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL bp_mem_req got=%b want=0", mem_req); end
        checks++; if (i_valid !== 1'b1 || i_reg !== 16'h0493) begin failures++; $display("[TB] FAIL bp_head valid=%b reg=%h want valid=1 reg=0493", i_valid, i_reg); end
        checks++; if (held !== 16'h0493) begin failures++; $display("[TB] FAIL bp_held got=%h want=0493", held); end
        fetch_log.delete();
        deliv_log.delete();
        i_ready = 1'b1;
        tick(10);
        checks++; if (deliv_log.size() < 2 || deliv_log[0] !== 16'h0493 || deliv_log[1] !== 16'h8190) begin failures++; $display("[TB] FAIL bp_release n=%0d w0=%h w1=%h want 0493 8190", deliv_log.size(), (deliv_log.size() > 0) ? deliv_log[0] : 16'hxxxx, (deliv_log.size() > 1) ? deliv_log[1] : 16'hxxxx); end
        checks++; if (fetch_log.size() < 1 || fetch_log[0] !== 16'h0002) begin failures++; $display("[TB] FAIL bp_resume_addr got=%h want=0002", (fetch_log.size() > 0) ? fetch_log[0] : 16'hxxxx); end
    endtask

    task automatic test_redirect_drain();
        bit found = 0;
        apply_reset();
        ack_delay = 3;
        i_ready   = 1'b1;
        for (int n = 0; n < 60 && !found; n++) begin
            tick(1);
            if (mem_req === 1'b1 && mem_addr === 16'h0003) found = 1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("[TB] FAIL drain_wait_addr3 got=timeout want=mem_req at 0003");
        end else begin
            fetch_log.delete();
            deliv_log.delete();
            redirect    = 1'b1;
            redirect_pc = 16'h0040;
            tick(1);
            redirect = 1'b0;
            checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0003) begin failures++; $display("[TB] FAIL drain_hold req=%b addr=%h want req=1 addr=0003", mem_req, mem_addr); end
            checks++; if (i_valid !== 1'b0) begin failures++; $display("[TB] FAIL drain_i_valid got=%b want=0", i_valid); end
            tick(2);
            checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0003) begin failures++; $display("[TB] FAIL drain_hold2 req=%b addr=%h want req=1 addr=0003", mem_req, mem_addr); end
            tick(20);
            checks++; if (fetch_log.size() < 2 || fetch_log[0] !== 16'h0003 || fetch_log[1] !== 16'h0040) begin failures++; $display("[TB] FAIL drain_addrs n=%0d a0=%h a1=%h want 0003 0040", fetch_log.size(), (fetch_log.size() > 0) ? fetch_log[0] : 16'hxxxx, (fetch_log.size() > 1) ? fetch_log[1] : 16'hxxxx); end
            checks++; if (deliv_log.size() < 1 || deliv_log[0] !== 16'h5A40) begin failures++; $display("[TB] FAIL drain_first_word got=%h want=5a40", (deliv_log.size() > 0) ? deliv_log[0] : 16'hxxxx); end
        end
    endtask

    task automatic test_redirect_ack();
        apply_reset();
        tick(1);
        checks++; if (mem_req !== 1'b1 || mem_ack !== 1'b1) begin failures++; $display("[TB] FAIL rack_setup req=%b ack=%b want 1 1", mem_req, mem_ack); end
        redirect    = 1'b1;
        redirect_pc = 16'h0020;
        tick(1);
        redirect = 1'b0;
        checks++; if (i_valid !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("[TB] FAIL rack_discard valid=%b req=%b want 0 0", i_valid, mem_req); end
        tick(1);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0020) begin failures++; $display("[TB] FAIL rack_next_addr req=%b addr=%h want req=1 addr=0020", mem_req, mem_addr); end
        tick(1);
        checks++; if (i_valid !== 1'b1 || i_reg !== 16'h5A20) begin failures++; $display("[TB] FAIL rack_word valid=%b reg=%h want valid=1 reg=5a20", i_valid, i_reg); end
    endtask

    task automatic test_halt();
        apply_reset();
        redirect    = 1'b1;
        redirect_pc = 16'h0010;
        tick(1);
        redirect = 1'b0;
        tick(6);
        checks++; if (i_valid !== 1'b1 || i_reg !== 16'h0010) begin failures++; $display("[TB] FAIL halt_setup valid=%b reg=%h want valid=1 reg=0010", i_valid, i_reg); end
        i_ready = 1'b1;
        halt    = 1'b1;
        tick(1);
        halt    = 1'b0;
        i_ready = 1'b0;
        checks++; if (i_valid !== 1'b1 || i_reg !== 16'h0011 || mem_req !== 1'b0) begin failures++; $display("[TB] FAIL halt_after_pop valid=%b reg=%h req=%b want 1 0011 0", i_valid, i_reg, mem_req); end
        fetch_log.delete();
        deliv_log.delete();
        i_ready = 1'b1;
        tick(6);
        checks++; if (deliv_log.size() != 1 || deliv_log[0] !== 16'h0011) begin failures++; $display("[TB] FAIL halt_drain n=%0d w0=%h want n=1 w0=0011", deliv_log.size(), (deliv_log.size() > 0) ? deliv_log[0] : 16'hxxxx); end
        checks++; if (fetch_log.size() != 0 || mem_req !== 1'b0) begin failures++; $display("[TB] FAIL halt_no_fetch n=%0d req=%b want n=0 req=0", fetch_log.size(), mem_req); end
        fetch_log.delete();
        redirect    = 1'b1;
        redirect_pc = 16'h0000;
        tick(1);
        redirect = 1'b0;
        tick(4);
        checks++; if (fetch_log.size() < 1 || fetch_log[0] !== 16'h0000) begin failures++; $display("[TB] FAIL halt_restart n=%0d a0=%h want a0=0000", fetch_log.size(), (fetch_log.size() > 0) ? fetch_log[0] : 16'hxxxx); end
    endtask

    task automatic test_wrap();
        apply_reset();
        i_ready     = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'hFFFF;
        tick(1);
        redirect = 1'b0;
        fetch_log.delete();
        deliv_log.delete();
        tick(8);
        checks++; if (fetch_log.size() < 2 || fetch_log[0] !== 16'hFFFF || fetch_log[1] !== 16'h0000) begin failures++; $display("[TB] FAIL wrap_addrs n=%0d a0=%h a1=%h want ffff 0000", fetch_log.size(), (fetch_log.size() > 0) ? fetch_log[0] : 16'hxxxx, (fetch_log.size() > 1) ? fetch_log[1] : 16'hxxxx); end
        checks++; if (deliv_log.size() < 2 || deliv_log[0] !== 16'hA5FF || deliv_log[1] !== 16'h0493) begin failures++; $display("[TB] FAIL wrap_words n=%0d w0=%h w1=%h want a5ff 0493", deliv_log.size(), (deliv_log.size() > 0) ? deliv_log[0] : 16'hxxxx, (deliv_log.size() > 1) ? deliv_log[1] : 16'hxxxx); end
    endtask

`ifdef IF_PERF_CNT_EN
    task automatic test_perf_cnt();
        apply_reset();
        ack_en  = 1'b0;
        i_ready = 1'b1;
        tick(10);
        checks++; if (stall_cnt !== 16'd10) begin failures++; $display("[TB] FAIL perf_starve got=%0d want=10", stall_cnt); end
        halt = 1'b1;
        tick(1);
        halt = 1'b0;
        tick(5);
        checks++; if (stall_cnt !== 16'd11) begin failures++; $display("[TB] FAIL perf_halted got=%0d want=11", stall_cnt); end
        ack_en = 1'b1;
    endtask
`endif

    initial begin
        wait_cnt = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drain();
        test_redirect_ack();
        test_halt();
        test_wrap();
`ifdef IF_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
